maxpool_2x2_reduce: RTL and testbench

Pipelined 2x2 max-pool reducer for the VGG16 inference datapath. It sits directly downstream of the max-pool line buffer and consumes its four-pixel window beats (top-left, top-right, bottom-left, bottom-right). For each window it emits the maximum IEEE-754 single-precision value. It also tracks position within the pooled feature map and flags the last output of each map for the next conv layer's buffer.

---
 rtl/maxpool_2x2_reduce.sv | 70 +++++++
 tb/tb_maxpool_2x2_reduce.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_2x2_reduce.sv
// rtl/maxpool_2x2_reduce.sv - two-stage 2x2 max-pool reducer with pooled-map position tracking
module maxpool_2x2_reduce #(
  parameter int DATA_WIDTH  = 32,
  parameter int IMAGE_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data_0,
  input  logic [DATA_WIDTH-1:0] i_data_1,
  input  logic [DATA_WIDTH-1:0] i_data_2,
  input  logic [DATA_WIDTH-1:0] i_data_3,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last
);

  localparam int OUT_SIDE = IMAGE_WIDTH / 2;
  localparam int CNT_MAX  = OUT_SIDE * OUT_SIDE - 1;
  localparam int CW       = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(CNT_MAX);

  logic                  v1;
  logic [DATA_WIDTH-1:0] m01;
  logic [DATA_WIDTH-1:0] m23;
  logic [CW-1:0]         cnt;

  // Sign-magnitude total order; ties keep a so -0/+0 and NaN need no special handling.
  function automatic logic [DATA_WIDTH-1:0] fmax(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH-1:0] r;
    r = a;
    if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) begin
      r = a[DATA_WIDTH-1] ? b : a;
    end else if (!a[DATA_WIDTH-1]) begin
      if (b[DATA_WIDTH-2:0] > a[DATA_WIDTH-2:0]) r = b;
    end else begin
      if (b[DATA_WIDTH-2:0] < a[DATA_WIDTH-2:0]) r = b;
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      m01     <= '0;
      m23     <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
      cnt     <= '0;
    end else begin
      v1 <= i_valid;
      // Gate on valid so idle-cycle X/Z from upstream never reaches a register.
      if (i_valid) begin
        m01 <= fmax(i_data_0, i_data_1);
        m23 <= fmax(i_data_2, i_data_3);
      end
      o_valid <= v1;
      o_last  <= v1 && (cnt == LAST_IDX);
      if (v1) begin
        o_data <= fmax(m01, m23);
        cnt    <= (cnt == LAST_IDX) ? '0 : cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_maxpool_2x2_reduce.sv
// tb/tb_maxpool_2x2_reduce.sv - directed and randomized checks for maxpool_2x2_reduce
module tb_maxpool_2x2_reduce;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] i_data_0, i_data_1, i_data_2, i_data_3;
  logic        o_valid;
  logic [31:0] o_data;
  logic        o_last;

  int checks = 0;
  int errors = 0;

  maxpool_2x2_reduce #(.DATA_WIDTH(32), .IMAGE_WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (i_valid),
    .i_data_0 (i_data_0),
    .i_data_1 (i_data_1),
    .i_data_2 (i_data_2),
    .i_data_3 (i_data_3),
    .o_valid  (o_valid),
    .o_data   (o_data),
    .o_last   (o_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one beat (idle beats float the data bus), clock it, settle past the edge.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [31:0] d);
    i_valid  = v;
    i_data_0 = v ? a : 'z;
    i_data_1 = v ? b : 'z;
    i_data_2 = v ? c : 'z;
    i_data_3 = v ? d : 'z;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    i_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monotone unsigned key for sign-magnitude ordering.
  function automatic logic [31:0] fkey(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b);
    return (fkey(b) > fkey(a)) ? b : a;
  endfunction

  function automatic logic [31:0] rand_float();
    logic [31:0] x;
    x = $urandom;
    if ($urandom_range(0, 7) == 0) x[30:0] = '0;
    if (x[30:23] == 8'hFF) x[22:0] = '0;
    return x;
  endfunction

  initial begin
    logic        pv;
    logic [31:0] pd;
    logic [31:0] hold;
    int          cnt;
    logic [31:0] r0, r1, r2, r3;
    logic        rv;

    i_valid = 1'b0;
    i_data_0 = '0; i_data_1 = '0; i_data_2 = '0; i_data_3 = '0;
    do_reset();
    check("reset_valid", {31'b0, o_valid}, 32'd0);
    check("reset_data", o_data, 32'd0);
    check("reset_last", {31'b0, o_last}, 32'd0);

    // Single mixed-sign window
    step(1'b1, 32'h3F80_0000, 32'h4000_0000, 32'hC040_0000, 32'h3F00_0000);
    check("single_lat_valid", {31'b0, o_valid}, 32'd0);
    idle();
    check("single_valid", {31'b0, o_valid}, 32'd1);
    check("single_data", o_data, 32'h4000_0000);
    check("single_last", {31'b0, o_last}, 32'd0);
    idle();
    check("single_pulse_end", {31'b0, o_valid}, 32'd0);
    check("single_hold", o_data, 32'h4000_0000);

    // All-negative and signed-zero windows back to back
    step(1'b1, 32'hBF80_0000, 32'hC040_0000, 32'hBF80_0000, 32'hC040_0000);
    step(1'b1, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000);
    check("neg_valid", {31'b0, o_valid}, 32'd1);
    check("neg_data", o_data, 32'hBF80_0000);
    idle();
    check("zero_valid", {31'b0, o_valid}, 32'd1);
    check("zero_data", o_data, 32'h0000_0000);
    idle();
    check("zero_end", {31'b0, o_valid}, 32'd0);

    // Eight back-to-back windows: o_last on the 4th and 8th
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(i < 8, 32'h3F80_0000 + i, 32'h4000_0000 + i, 32'hC000_0000, 32'h3F00_0000);
      if (i == 0 || i == 9) begin
        check("burst_edge_valid", {31'b0, o_valid}, 32'd0);
      end else begin
        check("burst_valid", {31'b0, o_valid}, 32'd1);
        check("burst_data", o_data, 32'h4000_0000 + (i - 1));
        check("burst_last", {31'b0, o_last}, {31'b0, ((i - 1) % 4) == 3});
      end
    end

    // Valid pattern 1,0,1,1,0 with Z on idle beats; counter continues from 0
    step(1'b1, 32'h4100_0000, 32'h3F80_0000, 32'hC100_0000, 32'h0000_0000);
    check("gap0_valid", {31'b0, o_valid}, 32'd0);
    idle();
    check("gap1_valid", {31'b0, o_valid}, 32'd1);
    check("gap1_data", o_data, 32'h4100_0000);
    step(1'b1, 32'h3F80_0000, 32'h4110_0000, 32'h4100_0000, 32'h8000_0000);
    check("gap2_valid", {31'b0, o_valid}, 32'd0);
    check("gap2_hold", o_data, 32'h4100_0000);
    step(1'b1, 32'hC080_0000, 32'hC000_0000, 32'hC100_0000, 32'hC180_0000);
    check("gap3_valid", {31'b0, o_valid}, 32'd1);
    check("gap3_data", o_data, 32'h4110_0000);
    idle();
    check("gap4_valid", {31'b0, o_valid}, 32'd1);
    check("gap4_data", o_data, 32'hC000_0000);
    check("gap4_last", {31'b0, o_last}, 32'd0);
    idle();
    check("gap5_valid", {31'b0, o_valid}, 32'd0);
    check("gap5_hold", o_data, 32'hC000_0000);

    // Two windows, then reset while the second sits in stage 1
    step(1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
    step(1'b1, 32'h4040_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
    check("pre_rst_valid", {31'b0, o_valid}, 32'd1);
    check("pre_rst_data", o_data, 32'h3F80_0000);
    check("pre_rst_last", {31'b0, o_last}, 32'd1);
    rst_n   = 1'b0;
    i_valid = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, o_valid}, 32'd0);
    check("async_rst_data", o_data, 32'd0);
    check("async_rst_last", {31'b0, o_last}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    check("discard_valid", {31'b0, o_valid}, 32'd0);
    check("discard_data", o_data, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(i < 4, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'h4080_0000 + i);
      if (i > 0) begin
        check("post_rst_valid", {31'b0, o_valid}, 32'd1);
        check("post_rst_data", o_data, 32'h4080_0000 + (i - 1));
        check("post_rst_last", {31'b0, o_last}, {31'b0, i == 4});
      end
    end
    idle();
    check("post_rst_end", {31'b0, o_valid}, 32'd0);

    // Randomized stream against a key-ordered reference
    do_reset();
    pv   = 1'b0;
    pd   = 32'h0;
    hold = 32'h0;
    cnt  = 0;
    for (int n = 0; n < 10000; n++) begin
      rv = ($urandom_range(0, 7) != 0);
      r0 = rand_float(); r1 = rand_float(); r2 = rand_float(); r3 = rand_float();
      step(rv, r0, r1, r2, r3);
      if (n > 0) begin
        check("rand_valid", {31'b0, o_valid}, {31'b0, pv});
        if (pv) hold = pd;
        check("rand_data", o_data, hold);
        check("rand_last", {31'b0, o_last}, {31'b0, pv && cnt == 3});
        if (pv) cnt = (cnt == 3) ? 0 : cnt + 1;
      end
      pv = rv;
      pd = ref_max(ref_max(r0, r1), ref_max(r2, r3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
